mmio_byte_master: RTL and testbench
===================================

# mmio_byte_master

Bus initiator that converts one CPU load/store (byte, half, word) into a sequence of single-byte request/response transactions on the 8-bit memory-mapped peripheral bus. Each peripheral answers every request with a one-cycle data-valid pulse and presents read data combinationally from the held address. Sits between the core's MMIO address decode and the byte-wide peripherals (GPIO, UART, timers). Provides little-endian assembly, alignment checking and a response timeout.

## Interface
- `TIMEOUT`, 16: max cycles spent waiting for `i_data_DV` per byte before abort (≥2)
- `i_clk` in 1: clock, rising edge
- `i_rst_n` in 1: asynchronous active-low reset
- `i_cpu_request` in 1: start access; sampled only in IDLE
- `i_cpu_write` in 1: 1 = store, 0 = load
- `i_cpu_size` in 2: 0 byte, 1 half, 2 word; 3 is illegal and reported as error
- `i_cpu_address` in 12: byte address of access
- `i_cpu_wdata` in 32: store data; byte k sits in bits [8k+7:8k]
- `o_cpu_rdata` out 32: assembled load data, zero-extended
- `o_cpu_done` out 1: one-cycle completion pulse
- `o_cpu_error` out 1: valid with `o_cpu_done`; misaligned, illegal size or timeout
- `o_cpu_busy` out 1: high in every state except IDLE
- `o_request` out 1: one-cycle request strobe to peripheral
- `o_write` out 1: write qualifier for current byte
- `o_address` out 12: current byte address
- `o_data` out 8: current write byte
- `i_data` in 8: peripheral read byte, valid while `i_data_DV` is high
- `i_data_DV` in 1: peripheral response pulse

## Operation
- States: IDLE, REQ, WAIT, DONE. All outputs are registered or Moore-decoded from the state; no combinational CPU-to-bus path.
- IDLE + `i_cpu_request`: latch write, size, address and wdata; clear `o_cpu_rdata`; byte index k=0; N = 1/2/4 for size 0/1/2.
- Alignment: half needs addr[0]=0, word needs addr[1:0]=0. A misaligned access or size 3 goes IDLE→DONE with error set and never asserts `o_request`.
- REQ: `o_request`=1 for exactly one cycle. `o_address`=base+k. `o_write`=latched write. `o_data`=wdata[8k+7:8k]. Next state is WAIT; the timeout counter clears.
- WAIT: `o_address`, `o_write` and `o_data` stay held from REQ.
  - On `i_data_DV`, a load captures `i_data` into rdata[8k+7:8k].
  - Then, if k=N-1, go to DONE with error=0; otherwise k++ and go to REQ.
- WAIT timeout: if `TIMEOUT` cycles pass in WAIT without DV, go to DONE with error=1. Bytes not yet fetched stay 0.
- DONE: `o_cpu_done`=1 for one cycle, then go to IDLE. `o_cpu_rdata` and `o_cpu_error` hold until the next accepted request.
- Address arithmetic is 12-bit. With alignment enforced, base+k never wraps past 0xFFF.
- `i_cpu_request` outside IDLE is ignored; it is not queued. `i_data_DV` outside WAIT is ignored.

## Timing
- Reset value of every output is 0, including `o_cpu_rdata`. State resets to IDLE and k to 0.
- Request accepted at edge 0. REQ occupies cycle 1 and WAIT begins at cycle 2. A peripheral with registered DV (one cycle after the request) responds in cycle 2.
- With one-cycle responders, `o_cpu_done` goes high in cycle 2N+1: byte 3, half 5, word 9.
- An error from misalignment or illegal size gives done in cycle 1.
- Minimum spacing between back-to-back CPU accesses: the next request may be sampled in the cycle after done.
- DV in the last counted WAIT cycle (count = TIMEOUT-1) is treated as success. The timeout fires only when the count reaches TIMEOUT.
- Reset mid-access returns to IDLE immediately (asynchronously) and drops `o_request`/`o_cpu_busy`. A late DV from a peripheral is ignored because the block is in IDLE.

## Structure
- Shared package `mmio_pkg` holds:
  - the state enum (IDLE/REQ/WAIT/DONE);
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - `MMIO_ADDR_W`=12 and `MMIO_DATA_W`=8, reused by all peripheral responders.
- Single module. The timeout counter is $clog2(TIMEOUT+1) bits wide and inline; no sub-module is warranted.

## Test plan
- **Byte load:** the responder model returns 0xA5 at 0x000, with DV one cycle after each request. Load byte 0x000 → `o_request` in cycle 1, done in cycle 3, rdata=0x000000A5, error=0.
- **Word load:** model bytes 0x11, 0x22, 0x33, 0x44 at 0x010–0x013. Load word 0x010 → four requests at addresses 0x010..0x013, done in cycle 9, rdata=0x44332211.
- **Half store:** store half 0x0FE with wdata=0x0000BEEF → two write requests: (0x0FE, 0xEF) then (0x0FF, 0xBE). Done in cycle 5, error=0.
- **Misaligned or illegal:** load word at 0x002, and size=3 at 0x000 → zero `o_request` pulses, done in cycle 1 with error=1.
- **Timeout:** the responder never asserts DV, word load at 0x020 → exactly one request, done at cycle 2+TIMEOUT with error=1, rdata=0. A late DV afterwards has no effect.
- **Reset and ignore:** assert `i_rst_n`=0 during the WAIT of byte 2 of a word load, with a spurious DV in IDLE and a second `i_cpu_request` while busy → all outputs return to 0, there is no extra done, and the block then completes a fresh byte load normally.

Source files
------------

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared bus widths, size encodings and master state type for the byte-wide MMIO bus.
package mmio_pkg;
   localparam int MMIO_ADDR_W = 12;
   localparam int MMIO_DATA_W = 8;
   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
   function automatic logic [1:0] last_index(input logic [1:0] size);
      return size == SZ_WORD ? 2'd3 : size == SZ_HALF ? 2'd1 : 2'd0;
   endfunction
endpackage

// File: rtl/mmio_byte_master.sv
// mmio_byte_master: splits a CPU byte/half/word access into byte-wide request/response
// transactions with little-endian assembly, alignment checking and a response timeout.
module mmio_byte_master
   import mmio_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_cpu_request,
   input  logic                   i_cpu_write,
   input  logic [1:0]             i_cpu_size,
   input  logic [MMIO_ADDR_W-1:0] i_cpu_address,
   input  logic [31:0]            i_cpu_wdata,
   output logic [31:0]            o_cpu_rdata,
   output logic                   o_cpu_done,
   output logic                   o_cpu_error,
   output logic                   o_cpu_busy,
   output logic                   o_request,
   output logic                   o_write,
   output logic [MMIO_ADDR_W-1:0] o_address,
   output logic [MMIO_DATA_W-1:0] o_data,
   input  logic [MMIO_DATA_W-1:0] i_data,
   input  logic                   i_data_DV
);
   localparam int CW = $clog2(TIMEOUT + 1);
   state_t state, state_nxt;
   logic write_q;
   logic [1:0] size_q, k;
   logic [MMIO_ADDR_W-1:0] base;
   logic [31:0] wdata_q;
   logic [CW-1:0] cnt;
   logic bad, last, expire, accept;
   assign bad = i_cpu_size == 2'd3 || (i_cpu_size == SZ_HALF && i_cpu_address[0])
                || (i_cpu_size == SZ_WORD && i_cpu_address[1:0] != 2'd0);
   assign last = k == last_index(size_q);
   assign expire = !i_data_DV && cnt == CW'(TIMEOUT - 1);
   assign accept = state == IDLE && i_cpu_request;
   assign o_request = state == REQ;
   assign o_cpu_done = state == DONE;
   assign o_cpu_busy = state != IDLE;
   assign o_write = write_q;
   assign o_address = base + MMIO_ADDR_W'(k);
   assign o_data = wdata_q[{k, 3'b000} +: MMIO_DATA_W];
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) state <= IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: state_nxt = i_cpu_request ? (bad ? DONE : REQ) : IDLE;
         REQ:  state_nxt = WAIT;
         WAIT: state_nxt = i_data_DV ? (last ? DONE : REQ) : (expire ? DONE : WAIT);
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         write_q <= 1'b0;
         size_q <= SZ_BYTE;
         base <= '0;
         wdata_q <= '0;
         k <= 2'd0;
         cnt <= '0;
         o_cpu_rdata <= '0;
         o_cpu_error <= 1'b0;
      end else begin
         if (accept) begin
            write_q <= i_cpu_write;
            size_q <= i_cpu_size;
            base <= i_cpu_address;
            wdata_q <= i_cpu_wdata;
            k <= 2'd0;
            o_cpu_rdata <= '0;
            o_cpu_error <= bad;
         end
         if (state == REQ) cnt <= '0;
         if (state == WAIT) begin
            cnt <= cnt + 1'b1;
            if (i_data_DV) begin
               if (!write_q) o_cpu_rdata[{k, 3'b000} +: MMIO_DATA_W] <= i_data;
               if (!last) k <= k + 2'd1;
            end else if (expire) o_cpu_error <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_mmio_byte_master.sv
// tb_mmio_byte_master: randomized and directed checks of mmio_byte_master against a byte-memory
// peripheral model with programmable response latency and response budget.
module tb_mmio_byte_master;
   localparam int TO = 16;
   logic i_clk = 0, i_rst_n = 0, i_cpu_request = 0, i_cpu_write = 0;
   logic [1:0] i_cpu_size = 0;
   logic [11:0] i_cpu_address = 0;
   logic [31:0] i_cpu_wdata = 0;
   logic [31:0] o_cpu_rdata;
   logic o_cpu_done, o_cpu_error, o_cpu_busy, o_request, o_write;
   logic [11:0] o_address;
   logic [7:0] o_data, i_data;
   logic i_data_DV;
   logic [7:0] mem [4096];
   logic resp_dv = 0, spur_dv = 0;
   int resp_budget = 1000000, resp_lat = 1;
   logic [20:0] req_q [$];
   int n_cmp = 0, n_bad = 0;

   mmio_byte_master #(.TIMEOUT(TO)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_cpu_request(i_cpu_request), .i_cpu_write(i_cpu_write),
      .i_cpu_size(i_cpu_size), .i_cpu_address(i_cpu_address), .i_cpu_wdata(i_cpu_wdata),
      .o_cpu_rdata(o_cpu_rdata), .o_cpu_done(o_cpu_done), .o_cpu_error(o_cpu_error),
      .o_cpu_busy(o_cpu_busy), .o_request(o_request), .o_write(o_write), .o_address(o_address),
      .o_data(o_data), .i_data(i_data), .i_data_DV(i_data_DV)
   );

   always #5 i_clk = ~i_clk;
   assign i_data = mem[o_address];
   assign i_data_DV = resp_dv | spur_dv;

   // Peripheral: logs every request, applies writes, answers after resp_lat edges while budget lasts.
   initial begin
      forever begin
         @(negedge i_clk);
         if (o_request === 1'b1) begin
            req_q.push_back({o_write, o_address, o_data});
            if (o_write) mem[o_address] = o_data;
            if (resp_budget > 0) begin
               resp_budget--;
               repeat (resp_lat) @(posedge i_clk);
               #1 resp_dv = 1;
               @(posedge i_clk);
               #1 resp_dv = 0;
            end
         end
      end
   end

   task automatic do_access(input logic w, input logic [1:0] sz, input logic [11:0] a,
                            input logic [31:0] wd, output int cyc, output logic [31:0] rd,
                            output logic er);
      req_q.delete();
      @(posedge i_clk); #1;
      i_cpu_request = 1; i_cpu_write = w; i_cpu_size = sz; i_cpu_address = a; i_cpu_wdata = wd;
      @(posedge i_clk); #1;
      i_cpu_request = 0;
      cyc = -1; rd = 'x; er = 'x;
      for (int c = 1; c <= 200; c++) begin
         if (o_cpu_done === 1'b1) begin
            cyc = c; rd = o_cpu_rdata; er = o_cpu_error;
            break;
         end
         @(posedge i_clk); #1;
      end
   endtask

   task automatic test_reset;
      #2;
      n_cmp++;
      if ({o_cpu_rdata, o_cpu_done, o_cpu_error, o_cpu_busy, o_request, o_write, o_address, o_data} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs got rdata=%h done=%b err=%b busy=%b req=%b wr=%b addr=%h data=%h want all 0",
                  o_cpu_rdata, o_cpu_done, o_cpu_error, o_cpu_busy, o_request, o_write, o_address, o_data);
      end
      @(posedge i_clk); #1 i_rst_n = 1;
   endtask

   task automatic test_byte_load;
      int cyc; logic [31:0] rd; logic er;
      mem[12'h000] = 8'hA5; resp_lat = 1;
      do_access(0, 2'd0, 12'h000, 32'h0, cyc, rd, er);
      n_cmp++; if (cyc !== 3) begin n_bad++; $display("FAIL byte_cycles got %0d want 3", cyc); end
      n_cmp++; if (rd !== 32'h000000A5 || er !== 1'b0) begin n_bad++; $display("FAIL byte_data got %h/%b want 000000a5/0", rd, er); end
      n_cmp++; if (req_q.size() != 1 || req_q[0][20:8] !== {1'b0, 12'h000}) begin n_bad++; $display("FAIL byte_requests got n=%0d want 1 read at 000", req_q.size()); end
      @(posedge i_clk); #1;
      n_cmp++; if (o_cpu_done !== 0 || o_cpu_busy !== 0 || o_cpu_rdata !== 32'hA5) begin n_bad++; $display("FAIL byte_after got done=%b busy=%b rdata=%h want 0/0/a5", o_cpu_done, o_cpu_busy, o_cpu_rdata); end
   endtask

   task automatic test_word_load;
      int cyc; logic [31:0] rd; logic er;
      for (int i = 0; i < 4; i++) mem[12'h010 + i] = 8'(8'h11 * (i + 1));
      do_access(0, 2'd2, 12'h010, 32'h0, cyc, rd, er);
      n_cmp++; if (cyc !== 9) begin n_bad++; $display("FAIL word_cycles got %0d want 9", cyc); end
      n_cmp++; if (rd !== 32'h44332211 || er !== 1'b0) begin n_bad++; $display("FAIL word_data got %h/%b want 44332211/0", rd, er); end
      n_cmp++; if (req_q.size() != 4) begin n_bad++; $display("FAIL word_reqcount got %0d want 4", req_q.size()); end
      for (int i = 0; i < req_q.size() && i < 4; i++) begin
         n_cmp++;
         if (req_q[i][20:8] !== {1'b0, 12'(12'h010 + i)}) begin n_bad++; $display("FAIL word_addr%0d got %h want %h", i, req_q[i][19:8], 12'h010 + i); end
      end
   endtask

   task automatic test_half_store;
      int cyc; logic [31:0] rd; logic er;
      do_access(1, 2'd1, 12'h0FE, 32'h0000BEEF, cyc, rd, er);
      n_cmp++; if (cyc !== 5 || er !== 1'b0 || rd !== 32'h0) begin n_bad++; $display("FAIL half_store got cyc=%0d err=%b rdata=%h want 5/0/0", cyc, er, rd); end
      n_cmp++;
      if (req_q.size() != 2 || req_q[0] !== {1'b1, 12'h0FE, 8'hEF} || req_q[1] !== {1'b1, 12'h0FF, 8'hBE}) begin
         n_bad++; $display("FAIL half_requests got n=%0d first=%h want 2 writes 1_0fe_ef,1_0ff_be", req_q.size(), req_q.size() ? req_q[0] : 21'h0);
      end
   endtask

   task automatic test_misaligned;
      int cyc; logic [31:0] rd; logic er;
      do_access(0, 2'd2, 12'h002, 32'h0, cyc, rd, er);
      n_cmp++; if (cyc !== 1 || er !== 1'b1 || req_q.size() != 0) begin n_bad++; $display("FAIL misaligned_word got cyc=%0d err=%b reqs=%0d want 1/1/0", cyc, er, req_q.size()); end
      do_access(0, 2'd3, 12'h000, 32'h0, cyc, rd, er);
      n_cmp++; if (cyc !== 1 || er !== 1'b1 || rd !== 0 || req_q.size() != 0) begin n_bad++; $display("FAIL illegal_size got cyc=%0d err=%b rdata=%h reqs=%0d want 1/1/0/0", cyc, er, rd, req_q.size()); end
   endtask

   task automatic test_timeout;
      int cyc; logic [31:0] rd; logic er;
      resp_budget = 0;
      do_access(0, 2'd2, 12'h020, 32'h0, cyc, rd, er);
      n_cmp++; if (cyc !== 2 + TO || er !== 1'b1 || rd !== 0) begin n_bad++; $display("FAIL timeout got cyc=%0d err=%b rdata=%h want %0d/1/0", cyc, er, rd, 2 + TO); end
      n_cmp++; if (req_q.size() != 1) begin n_bad++; $display("FAIL timeout_reqs got %0d want 1", req_q.size()); end
      @(posedge i_clk); #1 spur_dv = 1;
      @(posedge i_clk); #1 spur_dv = 0;
      @(posedge i_clk); #1;
      n_cmp++; if (o_cpu_done !== 0 || o_cpu_busy !== 0 || o_cpu_error !== 1 || o_cpu_rdata !== 0) begin n_bad++; $display("FAIL late_dv got done=%b busy=%b err=%b rdata=%h want 0/0/1/0", o_cpu_done, o_cpu_busy, o_cpu_error, o_cpu_rdata); end
      resp_budget = 1000000;
      mem[12'h030] = 8'h5C; resp_lat = TO;
      do_access(0, 2'd0, 12'h030, 32'h0, cyc, rd, er);
      n_cmp++; if (cyc !== 2 + TO || er !== 1'b0 || rd !== 32'h5C) begin n_bad++; $display("FAIL dv_last_cycle got cyc=%0d err=%b rdata=%h want %0d/0/5c", cyc, er, rd, 2 + TO); end
      resp_lat = TO + 1;
      do_access(0, 2'd0, 12'h030, 32'h0, cyc, rd, er);
      n_cmp++; if (cyc !== 2 + TO || er !== 1'b1 || rd !== 0) begin n_bad++; $display("FAIL dv_too_late got cyc=%0d err=%b rdata=%h want %0d/1/0", cyc, er, rd, 2 + TO); end
      repeat (3) @(posedge i_clk);
      resp_lat = 1;
   endtask

   task automatic test_reset_ignore;
      int cyc, dones; logic [31:0] rd; logic er;
      for (int i = 0; i < 4; i++) mem[12'h100 + i] = 8'($urandom);
      resp_budget = 2; req_q.delete(); dones = 0;
      @(posedge i_clk); #1;
      i_cpu_request = 1; i_cpu_write = 0; i_cpu_size = 2'd2; i_cpu_address = 12'h100;
      for (int c = 1; c <= 7; c++) begin
         @(posedge i_clk); #1;
         i_cpu_request = (c == 3);
         if (o_cpu_done === 1'b1) dones++;
      end
      i_rst_n = 0;
      #1;
      n_cmp++;
      if ({o_cpu_rdata, o_cpu_done, o_cpu_error, o_cpu_busy, o_request, o_write, o_address, o_data} !== '0) begin
         n_bad++; $display("FAIL midreset_outputs got rdata=%h busy=%b req=%b addr=%h want all 0", o_cpu_rdata, o_cpu_busy, o_request, o_address);
      end
      n_cmp++;
      if (req_q.size() != 3 || req_q[2][19:8] !== 12'h102) begin n_bad++; $display("FAIL midreset_reqs got n=%0d want 3 ending at 102", req_q.size()); end
      @(posedge i_clk); #1 i_rst_n = 1;
      for (int c = 0; c < 6; c++) begin
         spur_dv = (c == 2);
         @(posedge i_clk); #1;
         if (o_cpu_done === 1'b1 || o_cpu_busy !== 1'b0) dones++;
      end
      spur_dv = 0;
      n_cmp++; if (dones != 0) begin n_bad++; $display("FAIL midreset_quiet got %0d stray done/busy cycles want 0", dones); end
      resp_budget = 1000000;
      do_access(0, 2'd0, 12'h103, 32'h0, cyc, rd, er);
      n_cmp++; if (cyc !== 3 || er !== 0 || rd !== {24'h0, mem[12'h103]}) begin n_bad++; $display("FAIL post_reset_load got cyc=%0d err=%b rdata=%h want 3/0/%h", cyc, er, rd, mem[12'h103]); end
   endtask

   task automatic test_random;
      int cyc, n, exp_cyc; logic [31:0] rd, exp_rd, wd; logic er, w, bad, tmo; logic [1:0] sz; logic [11:0] a;
      for (int it = 0; it < 30; it++) begin
         w = 1'($urandom); sz = 2'($urandom); a = 12'($urandom); wd = $urandom;
         if ($urandom_range(0, 3) != 0) a = a & ~12'(sz == 2 ? 3 : sz == 1 ? 1 : 0);
         case ($urandom_range(0, 7))
            0: resp_lat = TO;
            1: resp_lat = TO + 1;
            default: resp_lat = $urandom_range(1, 3);
         endcase
         n = 1 << sz;
         bad = sz == 3 || (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 0);
         tmo = !bad && resp_lat > TO;
         exp_rd = 0;
         if (!w && !bad && !tmo)
            for (int i = 0; i < n; i++) exp_rd[8*i +: 8] = mem[12'(a + i)];
         exp_cyc = bad ? 1 : tmo ? 2 + TO : 1 + n * (1 + resp_lat);
         do_access(w, sz, a, wd, cyc, rd, er);
         n_cmp++;
         if (cyc !== exp_cyc || rd !== exp_rd || er !== (bad || tmo)) begin
            n_bad++; $display("FAIL rand%0d w=%b sz=%0d a=%h got cyc=%0d rdata=%h err=%b want %0d/%h/%b", it, w, sz, a, cyc, rd, er, exp_cyc, exp_rd, bad || tmo);
         end
         n_cmp++;
         if (req_q.size() != (bad ? 0 : tmo ? 1 : n)) begin n_bad++; $display("FAIL rand%0d_reqcount got %0d", it, req_q.size()); end
         else for (int i = 0; i < req_q.size(); i++)
            if (req_q[i][20:8] !== {w, 12'(a + i)} || (w && req_q[i][7:0] !== wd[8*i +: 8])) begin
               n_bad++; $display("FAIL rand%0d_req%0d got %h want w=%b addr=%h data=%h", it, i, req_q[i], w, 12'(a + i), wd[8*i +: 8]);
            end
         if (tmo) repeat (3) @(posedge i_clk);
      end
      resp_lat = 1;
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
      test_reset;
      test_byte_load;
      test_word_load;
      test_half_store;
      test_misaligned;
      test_timeout;
      test_reset_ignore;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
